// File: rtl/pencere_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pencere_pkg
// Description : Shared types and constants for the 3x3 window generator:
//               FSM state encoding, window tap indices and counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pencere_pkg;

    // Handshake FSM: ACCEPT takes pixels, HOLD presents a window until acked
    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_HOLD   = 1'b1
    } state_t;

    // Window tap indices, row-major, TL is oldest row / oldest column
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;
    localparam int WIN_N  = 9;

    // Width of the per-frame window statistics counter
    localparam int c_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/pencere_uretici_if.sv
`default_nettype none
// ============================================================================
// Interface   : pencere_uretici_if
// Description : Pixel-in / window-out bundle of the 3x3 window generator.
//               master = window generator, slave = pixel source + consumer.
//               Optional macro PENCERE_STATS_EN adds win_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
interface pencere_uretici_if
    import pencere_pkg::*;
#(
    parameter int DATA_W = 8
) ();

    logic              pix_valid_i;
    logic              pix_sof_i;
    logic [DATA_W-1:0] pix_i;
    logic              pix_ready_o;
    logic              win_valid_o;
    logic              win_ack_i;
    logic [DATA_W-1:0] data_o0;
    logic [DATA_W-1:0] data_o1;
    logic [DATA_W-1:0] data_o2;
    logic [DATA_W-1:0] data_o3;
    logic [DATA_W-1:0] data_o4;
    logic [DATA_W-1:0] data_o5;
    logic [DATA_W-1:0] data_o6;
    logic [DATA_W-1:0] data_o7;
    logic [DATA_W-1:0] data_o8;
    logic              frame_done_o;
`ifdef PENCERE_STATS_EN
    logic [c_CNT_W-1:0] win_cnt_o;
`endif

    modport master (
        input  pix_valid_i, pix_sof_i, pix_i, win_ack_i,
        output pix_ready_o, win_valid_o,
        output data_o0, data_o1, data_o2, data_o3, data_o4,
        output data_o5, data_o6, data_o7, data_o8,
        output frame_done_o
`ifdef PENCERE_STATS_EN
        , output win_cnt_o
`endif
    );

    modport slave (
        output pix_valid_i, pix_sof_i, pix_i, win_ack_i,
        input  pix_ready_o, win_valid_o,
        input  data_o0, data_o1, data_o2, data_o3, data_o4,
        input  data_o5, data_o6, data_o7, data_o8,
        input  frame_done_o
`ifdef PENCERE_STATS_EN
        , input win_cnt_o
`endif
    );

endinterface
`default_nettype wire

// File: rtl/satir_tamponu.sv
`default_nettype none
// ============================================================================
// Module      : satir_tamponu
// Description : One image line of storage. Combinational read and
//               synchronous write at the same address, so a same-cycle
//               read returns the value from before the write.
//               Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module satir_tamponu #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic              clk,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic              i_we,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // Write the new value for this column; read above sees the old one
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pencere_uretici.sv
`default_nettype none
// ============================================================================
// Module      : pencere_uretici
// Description : 3x3 window generator. Buffers two previous lines of a raster
//               stream and presents each complete 3x3 neighbourhood in
//               parallel, holding it until the consumer acknowledges.
//               Optional macro PENCERE_STATS_EN adds a saturating per-frame
//               window counter (win_cnt_o).
// Revision    : 1.0 - initial release
// ============================================================================
module pencere_uretici
    import pencere_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pencere_uretici_if.master  bus
);

    localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_ready;
    logic                r_frame_done;
    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_COL_W-1:0]  w_col;
    logic [c_ROW_W-1:0]  w_row;
    logic [c_COL_W-1:0]  w_col_next;
    logic [c_ROW_W-1:0]  w_row_next;
    logic                w_accept;
    logic                w_sof;
    logic                w_win_done;
    logic                w_frame_end;
    logic [DATA_W-1:0]   w_lb0_rd;
    logic [DATA_W-1:0]   w_lb1_rd;
    logic [DATA_W-1:0]   r_win [WIN_N];

    // An SOF pixel is forced to (0,0) regardless of the running counters
    assign w_accept    = bus.pix_valid_i & r_ready;
    assign w_sof       = w_accept & bus.pix_sof_i;
    assign w_col       = w_sof ? '0 : r_col;
    assign w_row       = w_sof ? '0 : r_row;
    assign w_win_done  = w_accept & (w_row >= c_ROW_TWO) & (w_col >= c_COL_TWO);
    assign w_frame_end = w_accept & (w_row == c_ROW_LAST) & (w_col == c_COL_LAST);

    // lb0 holds line r-1, lb1 holds line r-2 for the current column
    satir_tamponu #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (c_COL_W)
    ) u_lb0 (
        .clk     (clk),
        .i_addr  (w_col),
        .i_we    (w_accept),
        .i_wdata (bus.pix_i),
        .o_rdata (w_lb0_rd)
    );

    satir_tamponu #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (c_COL_W)
    ) u_lb1 (
        .clk     (clk),
        .i_addr  (w_col),
        .i_we    (w_accept),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    // Raster position advance with line and frame wrap
    always_comb begin
        w_col_next = r_col;
        w_row_next = r_row;
        if (w_accept) begin
            if (w_col == c_COL_LAST) begin
                w_col_next = '0;
                w_row_next = (w_row == c_ROW_LAST) ? '0 : w_row + c_ROW_W'(1);
            end else begin
                w_col_next = w_col + c_COL_W'(1);
                w_row_next = w_row;
            end
        end
    end

    // Position counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end
    end

    // Next-state logic: a window-completing pixel enters HOLD, ack leaves it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCEPT: if (w_win_done)     w_state_next = ST_HOLD;
            ST_HOLD:   if (bus.win_ack_i)  w_state_next = ST_ACCEPT;
            default:                       w_state_next = ST_ACCEPT;
        endcase
    end

    // State register plus registered ready and frame-done outputs; ready
    // stays low during reset and rises on the first edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ACCEPT;
            r_ready      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ready      <= (w_state_next == ST_ACCEPT);
            r_frame_done <= w_frame_end;
        end
    end

    // 3x3 shift register: shift left, new right column from line buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN_N; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_accept) begin
            r_win[WIN_TL] <= r_win[WIN_TC];
            r_win[WIN_TC] <= r_win[WIN_TR];
            r_win[WIN_TR] <= w_lb1_rd;
            r_win[WIN_ML] <= r_win[WIN_MC];
            r_win[WIN_MC] <= r_win[WIN_MR];
            r_win[WIN_MR] <= w_lb0_rd;
            r_win[WIN_BL] <= r_win[WIN_BC];
            r_win[WIN_BC] <= r_win[WIN_BR];
            r_win[WIN_BR] <= bus.pix_i;
        end
    end

`ifdef PENCERE_STATS_EN
    logic [c_CNT_W-1:0] r_win_cnt;

    // Saturating windows-per-frame count, restarted by an SOF pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_cnt <= '0;
        end else if (w_sof) begin
            r_win_cnt <= w_win_done ? c_CNT_W'(1) : '0;
        end else if (w_win_done && (r_win_cnt != {c_CNT_W{1'b1}})) begin
            r_win_cnt <= r_win_cnt + c_CNT_W'(1);
        end
    end

    assign bus.win_cnt_o = r_win_cnt;
`endif

    assign bus.pix_ready_o  = r_ready;
    assign bus.win_valid_o  = (r_state == ST_HOLD);
    assign bus.frame_done_o = r_frame_done;
    assign bus.data_o0      = r_win[WIN_TL];
    assign bus.data_o1      = r_win[WIN_TC];
    assign bus.data_o2      = r_win[WIN_TR];
    assign bus.data_o3      = r_win[WIN_ML];
    assign bus.data_o4      = r_win[WIN_MC];
    assign bus.data_o5      = r_win[WIN_MR];
    assign bus.data_o6      = r_win[WIN_BL];
    assign bus.data_o7      = r_win[WIN_BC];
    assign bus.data_o8      = r_win[WIN_BR];

endmodule
`default_nettype wire
